// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline definitions: load-type encodings, datapath width defaults
// and the hard-wired zero register.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam int unsigned REG_ZERO = 0;

  localparam logic [2:0] LT_LW  = 3'd0;
  localparam logic [2:0] LT_LB  = 3'd1;
  localparam logic [2:0] LT_LBU = 3'd2;
  localparam logic [2:0] LT_LH  = 3'd3;
  localparam logic [2:0] LT_LHU = 3'd4;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Combinational big-endian load aligner: selects the addressed byte/halfword of a
// raw memory word and sign- or zero-extends it according to the load type.
module load_align
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] raw_word,
  input  logic [1:0]        byte_off,
  input  logic [2:0]        load_type,
  output logic [DATA_W-1:0] load_word
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = raw_word[DATA_W-1 -: 8];
    half_sel  = raw_word[DATA_W-1 -: 16];
    load_word = raw_word;

    // Offset 0 addresses the most significant byte; halfwords ignore off[0].
    case (byte_off)
      2'd0:    byte_sel = raw_word[DATA_W-1  -: 8];
      2'd1:    byte_sel = raw_word[DATA_W-9  -: 8];
      2'd2:    byte_sel = raw_word[DATA_W-17 -: 8];
      default: byte_sel = raw_word[DATA_W-25 -: 8];
    endcase

    if (byte_off[1]) begin
      half_sel = raw_word[DATA_W-17 -: 16];
    end

    case (load_type)
      LT_LB:   load_word = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  load_word = {{(DATA_W-8){1'b0}}, byte_sel};
      LT_LH:   load_word = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LT_LHU:  load_word = {{(DATA_W-16){1'b0}}, half_sel};
      default: load_word = raw_word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage with retired-instruction counter.
// Define MEM_WB_BYPASS_EN to forward the write-back value to the ID-stage reads.
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_mem_to_reg,
  input  logic [2:0]        mem_load_type,
  input  logic [1:0]        mem_byte_off,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic [DATA_W-1:0] id_rs_data_in,
  input  logic [DATA_W-1:0] id_rt_data_in,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [31:0]       retire_count
);

  logic              valid_q,        valid_d;
  logic              reg_write_q,    reg_write_d;
  logic              mem_to_reg_q,   mem_to_reg_d;
  logic [2:0]        load_type_q,    load_type_d;
  logic [1:0]        byte_off_q,     byte_off_d;
  logic [DATA_W-1:0] alu_result_q,   alu_result_d;
  logic [DATA_W-1:0] read_data_q,    read_data_d;
  logic [ADDR_W-1:0] rd_q,           rd_d;
  logic [31:0]       retire_count_q, retire_count_d;
  logic [DATA_W-1:0] load_word;

  always_comb begin
    valid_d        = valid_q;
    reg_write_d    = reg_write_q;
    mem_to_reg_d   = mem_to_reg_q;
    load_type_d    = load_type_q;
    byte_off_d     = byte_off_q;
    alu_result_d   = alu_result_q;
    read_data_d    = read_data_q;
    rd_d           = rd_q;
    retire_count_d = retire_count_q;

    // An instruction retires when it leaves WB normally; flushed ones never count.
    if (valid_q && !stall && !flush) begin
      retire_count_d = retire_count_q + 32'd1;
    end

    if (flush) begin
      valid_d      = 1'b0;
      reg_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
      load_type_d  = '0;
      byte_off_d   = '0;
      alu_result_d = '0;
      read_data_d  = '0;
      rd_d         = '0;
    end else if (!stall) begin
      valid_d      = mem_valid;
      reg_write_d  = mem_reg_write;
      mem_to_reg_d = mem_mem_to_reg;
      load_type_d  = mem_load_type;
      byte_off_d   = mem_byte_off;
      alu_result_d = mem_alu_result;
      read_data_d  = mem_read_data;
      rd_d         = mem_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q        <= 1'b0;
      reg_write_q    <= 1'b0;
      mem_to_reg_q   <= 1'b0;
      load_type_q    <= '0;
      byte_off_q     <= '0;
      alu_result_q   <= '0;
      read_data_q    <= '0;
      rd_q           <= '0;
      retire_count_q <= '0;
    end else begin
      valid_q        <= valid_d;
      reg_write_q    <= reg_write_d;
      mem_to_reg_q   <= mem_to_reg_d;
      load_type_q    <= load_type_d;
      byte_off_q     <= byte_off_d;
      alu_result_q   <= alu_result_d;
      read_data_q    <= read_data_d;
      rd_q           <= rd_d;
      retire_count_q <= retire_count_d;
    end
  end

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .raw_word  (read_data_q),
    .byte_off  (byte_off_q),
    .load_type (load_type_q),
    .load_word (load_word)
  );

  assign wb_valid     = valid_q;
  assign wb_reg_write = valid_q & reg_write_q & (rd_q != ADDR_W'(REG_ZERO));
  assign wb_addr      = rd_q;
  assign wb_data      = mem_to_reg_q ? load_word : alu_result_q;
  assign retire_count = retire_count_q;

`ifdef MEM_WB_BYPASS_EN
  // $0 never matches here because wb_reg_write is already low for rd == 0.
  assign id_rs_data = (wb_reg_write && (wb_addr == id_rs)) ? wb_data : id_rs_data_in;
  assign id_rt_data = (wb_reg_write && (wb_addr == id_rt)) ? wb_data : id_rt_data_in;
`else
  assign id_rs_data = id_rs_data_in;
  assign id_rt_data = id_rt_data_in;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes expected WB outputs computed by a
// behavioural model, and a monitor pops and compares them one edge later.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        mem_valid, mem_reg_write, mem_mem_to_reg;
  logic [2:0]  mem_load_type;
  logic [1:0]  mem_byte_off;
  logic [31:0] mem_alu_result, mem_read_data;
  logic [4:0]  mem_rd, id_rs, id_rt;
  logic [31:0] id_rs_data_in, id_rt_data_in, id_rs_data, id_rt_data;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, retire_count;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic        rst, stall, flush, valid, rw, m2r;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] alu, raw;
    logic [4:0]  rd, rs, rt;
    logic [31:0] rs_in, rt_in;
  } stim_t;

  typedef struct {
    logic        valid, rw;
    logic [4:0]  addr;
    logic [31:0] data, cnt, rs_data, rt_data;
  } exp_t;

  exp_t expq[$];

  // Model of what WB currently holds, kept as a plain record of the last instruction.
  stim_t       m_ins;
  logic [31:0] m_cnt;

  mem_wb_stage dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .mem_valid      (mem_valid),
    .mem_reg_write  (mem_reg_write),
    .mem_mem_to_reg (mem_mem_to_reg),
    .mem_load_type  (mem_load_type),
    .mem_byte_off   (mem_byte_off),
    .mem_alu_result (mem_alu_result),
    .mem_read_data  (mem_read_data),
    .mem_rd         (mem_rd),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_data_in  (id_rs_data_in),
    .id_rt_data_in  (id_rt_data_in),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .wb_valid       (wb_valid),
    .wb_reg_write   (wb_reg_write),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .retire_count   (retire_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] modelLoad(logic [31:0] word, logic [2:0] lt, logic [1:0] off);
    logic [31:0] b, h;
    b = (word >> (8 * (3 - int'(off)))) & 32'h0000_00FF;
    h = (off[1] ? word : (word >> 16)) & 32'h0000_FFFF;
    case (lt)
      3'd1:    return (b >= 32'd128) ? (b + 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return word;
    endcase
  endfunction

  function automatic stim_t clearedStim();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst   = ($urandom_range(63) == 0);
    s.stall = ($urandom_range(7) == 0);
    s.flush = ($urandom_range(15) == 0);
    s.valid = ($urandom_range(3) != 0);
    s.rw    = ($urandom_range(3) != 0);
    s.m2r   = $urandom_range(1);
    s.lt    = 3'($urandom_range(7));
    s.off   = 2'($urandom_range(3));
    s.alu   = $urandom;
    s.raw   = $urandom;
    s.rd    = 5'($urandom_range(7));
    s.rs    = 5'($urandom_range(7));
    s.rt    = 5'($urandom_range(7));
    s.rs_in = $urandom;
    s.rt_in = $urandom;
    return s;
  endfunction

  // Drives one cycle of inputs and pushes the WB outputs expected after the next edge.
  task automatic applyStimulus(input stim_t s);
    exp_t e;
    logic writes;
    @(negedge clk);
    rst            = s.rst;
    stall          = s.stall;
    flush          = s.flush;
    mem_valid      = s.valid;
    mem_reg_write  = s.rw;
    mem_mem_to_reg = s.m2r;
    mem_load_type  = s.lt;
    mem_byte_off   = s.off;
    mem_alu_result = s.alu;
    mem_read_data  = s.raw;
    mem_rd         = s.rd;
    id_rs          = s.rs;
    id_rt          = s.rt;
    id_rs_data_in  = s.rs_in;
    id_rt_data_in  = s.rt_in;

    if (s.rst) begin
      m_ins = clearedStim();
      m_cnt = 32'd0;
    end else begin
      if (m_ins.valid && !s.stall && !s.flush) m_cnt = m_cnt + 32'd1;
      if (s.flush)       m_ins = clearedStim();
      else if (!s.stall) m_ins = s;
    end

    writes    = m_ins.valid && m_ins.rw && (m_ins.rd != 5'd0);
    e.valid   = m_ins.valid;
    e.rw      = writes;
    e.addr    = m_ins.rd;
    e.data    = m_ins.m2r ? modelLoad(m_ins.raw, m_ins.lt, m_ins.off) : m_ins.alu;
    e.cnt     = m_cnt;
    e.rs_data = s.rs_in;
    e.rt_data = s.rt_in;
`ifdef MEM_WB_BYPASS_EN
    if (writes && (m_ins.rd == s.rs)) e.rs_data = e.data;
    if (writes && (m_ins.rd == s.rt)) e.rt_data = e.data;
`endif
    expq.push_back(e);
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField("wb_valid",     32'(wb_valid),     32'(e.valid));
    checkField("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
    checkField("wb_addr",      32'(wb_addr),      32'(e.addr));
    checkField("wb_data",      wb_data,           e.data);
    checkField("retire_count", retire_count,      e.cnt);
    checkField("id_rs_data",   id_rs_data,        e.rs_data);
    checkField("id_rt_data",   id_rt_data,        e.rt_data);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) checkOutput(expq.pop_front());
    end
  end

  initial begin : driver
    stim_t s;
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_mem_to_reg = 1'b0;
    mem_load_type = '0; mem_byte_off = '0; mem_alu_result = '0; mem_read_data = '0;
    mem_rd = '0; id_rs = '0; id_rt = '0; id_rs_data_in = '0; id_rt_data_in = '0;
    m_ins = clearedStim();
    m_cnt = 32'd0;

    $display("[TB] reset with random inputs");
    for (int i = 0; i < 2; i++) begin
      s = randStim(); s.rst = 1'b1; s.valid = 1'b1;
      applyStimulus(s);
    end

    $display("[TB] ALU write-back to r6");
    s = clearedStim(); s.valid = 1'b1; s.rw = 1'b1; s.alu = 32'h0000_0040; s.rd = 5'd6;
    applyStimulus(s);
    applyStimulus(clearedStim());

    $display("[TB] load alignment on 0x80FF7F01");
    for (int i = 0; i < 9; i++) begin
      logic [2:0] lts[9];
      logic [1:0] offs[9];
      lts  = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd1, 3'd1, 3'd0, 3'd5};
      offs = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1, 2'd1, 2'd3};
      s = clearedStim(); s.valid = 1'b1; s.rw = 1'b1; s.m2r = 1'b1;
      s.raw = 32'h80FF_7F01; s.rd = 5'd7; s.lt = lts[i]; s.off = offs[i];
      applyStimulus(s);
    end

    $display("[TB] write to r0 suppressed");
    s = clearedStim(); s.valid = 1'b1; s.rw = 1'b1; s.alu = 32'hDEAD_BEEF; s.rd = 5'd0;
    applyStimulus(s);

    $display("[TB] stall then stall with flush");
    s = clearedStim(); s.valid = 1'b1; s.rw = 1'b1; s.alu = 32'h0000_0999; s.rd = 5'd9;
    applyStimulus(s);
    for (int i = 0; i < 3; i++) begin
      s = randStim(); s.rst = 1'b0; s.flush = 1'b0; s.stall = 1'b1;
      applyStimulus(s);
    end
    s = randStim(); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b1;
    applyStimulus(s);
    applyStimulus(clearedStim());

    $display("[TB] ID bypass of r3");
    s = clearedStim(); s.valid = 1'b1; s.rw = 1'b1; s.alu = 32'h0000_1234; s.rd = 5'd3;
    s.rs = 5'd3; s.rs_in = 32'h0000_0003; s.rt = 5'd0; s.rt_in = 32'h0000_0055;
    applyStimulus(s);

    $display("[TB] reset during stall");
    s = randStim(); s.rst = 1'b0; s.stall = 1'b0; s.flush = 1'b0; s.valid = 1'b1;
    applyStimulus(s);
    s = randStim(); s.rst = 1'b1; s.stall = 1'b1;
    applyStimulus(s);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(randStim());
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
